stump_control_seq: RTL and testbench
====================================

Name: stump_control_seq

Overview:
- Next-generation Stump control unit: FSM sequencer plus instruction decoder in one block.
- Owns the state register, the instruction register and a memory-wait timeout counter.
- Supports variable-latency memory via a req/ack handshake and evaluates branch conditions internally.
- Sits between the memory interface and the Stump datapath, driving all datapath control lines.

Parameters:
- DATA_W, 16, instruction/memory data width; opcode fields are always taken from bits [15:0].
- REG_AW, 3, register address width; dest/srcA/srcB width; PC is register all-ones.
- TIMEOUT, 15, maximum cycles to wait for mem_ack before entering FAULT; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- mem_rdata  in  DATA_W  memory read data; instruction captured from here
- mem_ack  in  1  memory transfer complete, one-cycle pulse
- cc  in  4  condition codes {N,Z,V,C}
- fetch / execute / memory  out  1 each  one-hot current phase
- ir  out  DATA_W  current instruction register
- ext_op  out  1  immediate extension mode (0 = 5-bit, 1 = 8-bit branch)
- reg_write  out  1  register file write enable
- dest / srcA / srcB  out  REG_AW each  register addresses
- shift_op  out  2  shifter operation
- opB_mux_sel  out  1  1 selects immediate
- alu_func  out  3  ALU function
- cc_en  out  1  condition-code register enable
- mem_ren / mem_wen  out  1 each  memory read/write request, held until ack
- branch_taken  out  1  registered Testbranch result of the last BCC
- fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset: sampled on clk rising edge while rst_n = 0. Effects:
  - state <= FETCH, ir <= 0, wait counter <= 0, branch_taken <= 0, fault <= 0.
  - While rst_n = 0, all outputs are forced to 0 combinationally: enables, phase flags, addresses, alu_func.
  - Reset mid-transfer abandons the transfer; no write completes.
- States (2-bit encoding): FETCH = 00, EXECUTE = 01, MEMORY = 10, FAULT = 11.
- FETCH:
  - Outputs: fetch = 1, mem_ren = 1, dest = srcA = all-ones, alu_func = 000, shift_op = 00, cc_en = 0.
  - reg_write = mem_ack, so the PC increments only on the ack cycle.
  - On mem_ack: ir <= mem_rdata, counter cleared, next state EXECUTE. Otherwise the counter increments.
- EXECUTE: single cycle; decode on ir[15:13].
  - ALU ops 000-101:
    - dest = ir[10:8], srcA = ir[7:5], alu_func = ir[15:13], cc_en = ir[11], reg_write = 1.
    - ir[12] = 0: srcB = ir[4:2], shift_op = ir[1:0], opB_mux_sel = 0.
    - ir[12] = 1: ext_op = 0, opB_mux_sel = 1, shift_op = 00.
    - Next state FETCH.
  - LDST 110:
    - alu_func = 110, ext_op = 0, opB_mux_sel = 1, reg_write = 0, cc_en = 0, mem_ren = mem_wen = 0.
    - Next state MEMORY.
  - BCC 111:
    - dest = srcA = all-ones, alu_func = 111, ext_op = 1, opB_mux_sel = 1, cc_en = 0.
    - reg_write = Testbranch(ir[11:8], cc); branch_taken <= the same value.
    - Condition table, codes 0-15: always, never, ~(C|Z), C|Z, ~C, C, ~Z, Z, ~V, V, ~N, N, V~^N, V^N, ~((V^N)|Z), (V^N)|Z.
    - Next state FETCH.
- MEMORY:
  - Outputs: memory = 1.
  - Load (ir[11] = 0): mem_ren = 1, dest = ir[10:8], reg_write = mem_ack.
  - Store (ir[11] = 1): mem_wen = 1, srcA = ir[10:8], reg_write = 0.
  - On mem_ack: next state FETCH; otherwise the counter increments.
- Timeout:
  - In FETCH or MEMORY, if the counter reaches TIMEOUT with no ack, next state FAULT and fault <= 1.
  - An ack in the same cycle the counter reaches TIMEOUT wins: normal transition, no fault.
- FAULT:
  - All enables 0, phase flags 0, fault = 1.
  - Held until reset; mem_ack is ignored.
- Unused address fields are driven to 0, never x.
- Counter width is 8 bits and saturates; it clears on every state change.

Optional Feature:
- Macro: STUMP_CTRL_PERF_EN.
- Defined:
  - Adds outputs retired[31:0] and stall_cycles[31:0], both cleared by reset and wrap-around on overflow.
  - retired increments on each EXECUTE→FETCH transition and each MEMORY ack.
  - stall_cycles increments on every FETCH/MEMORY cycle with mem_ack = 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then fetch with ack on the 3rd cycle, mem_rdata = 16'h0123 (ADD R1,R1,R0): fetch held 3 cycles, reg_write only in the ack cycle, ir = 0123, next cycle execute = 1 with dest = 1, srcA = 1, srcB = 0, alu_func = 000.
- ir = 16'hC6E0 (LD R6,[R7,#0]) with ack delayed 2 cycles: EXECUTE, then MEMORY with mem_ren = 1 for 3 cycles, reg_write = 1 and dest = 6 only in the ack cycle, then FETCH.
- ir = 16'hE7xx (BCC cond 7, Z) with cc = 4'b0100: reg_write = 1, branch_taken = 1; repeat with cc = 0: reg_write = 0, branch_taken = 0.
- TIMEOUT = 4, no mem_ack in FETCH: fault asserts after 4 wait cycles, all enables go to 0; a late ack is ignored; rst_n = 0 for one cycle returns to FETCH with fault = 0.
- Ack arrives exactly on the TIMEOUT cycle: no fault, normal transition.
- With STUMP_CTRL_PERF_EN, run 5 instructions including 1 store with 2 waits: retired = 5, stall_cycles equals the total non-ack cycles counted.

Source files
------------

// File: rtl/stump_control_seq.sv
// Stump control unit: fetch/execute/memory sequencer, instruction decode and memory-wait timeout.
// Define STUMP_CTRL_PERF_EN to add the retired / stall_cycles performance counters.
//
// state   | meaning
// FETCH   | instruction read in flight; PC written on the ack cycle
// EXECUTE | single-cycle decode: ALU op, branch, or LDST address phase
// MEMORY  | load/store transfer waiting for mem_ack
// FAULT   | memory wait exceeded TIMEOUT; held until reset
module stump_control_seq #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [3:0]        cc,
    output logic              fetch,
    output logic              execute,
    output logic              memory,
    output logic [DATA_W-1:0] ir,
    output logic              ext_op,
    output logic              reg_write,
    output logic [REG_AW-1:0] dest,
    output logic [REG_AW-1:0] srcA,
    output logic [REG_AW-1:0] srcB,
    output logic [1:0]        shift_op,
    output logic              opB_mux_sel,
    output logic [2:0]        alu_func,
    output logic              cc_en,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic              branch_taken,
    output logic              fault
`ifdef STUMP_CTRL_PERF_EN
    ,
    output logic [31:0]       retired,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10,
        FAULT   = 2'b11
    } state_t;

    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;
    // Last wait cycle allowed: the TIMEOUT-th cycle without ack moves to FAULT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              branch_q;
    logic              fault_q;
    logic [2:0]        opcode;
    logic              waiting;
    logic              timeout_hit;
    logic              br_cond;

    function automatic logic test_branch(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, v, c;
        logic r;
        {n, z, v, c} = flags;
        r = 1'b0;
        case (cond)
            4'd0:  r = 1'b1;
            4'd1:  r = 1'b0;
            4'd2:  r = ~(c | z);
            4'd3:  r = c | z;
            4'd4:  r = ~c;
            4'd5:  r = c;
            4'd6:  r = ~z;
            4'd7:  r = z;
            4'd8:  r = ~v;
            4'd9:  r = v;
            4'd10: r = ~n;
            4'd11: r = n;
            4'd12: r = v ~^ n;
            4'd13: r = v ^ n;
            4'd14: r = ~((v ^ n) | z);
            4'd15: r = (v ^ n) | z;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign opcode      = ir_q[15:13];
    assign br_cond     = test_branch(ir_q[11:8], cc);
    assign waiting     = (state_q == FETCH) || (state_q == MEMORY);
    assign timeout_hit = waiting && !mem_ack && (wait_cnt_q >= WAIT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem_ack)          state_d = EXECUTE;
                else if (timeout_hit) state_d = FAULT;
            end
            EXECUTE: state_d = (opcode == OP_LDST) ? MEMORY : FETCH;
            MEMORY: begin
                if (mem_ack)          state_d = FETCH;
                else if (timeout_hit) state_d = FAULT;
            end
            default: state_d = FAULT;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (waiting && !mem_ack && wait_cnt_q != 8'hFF)
            wait_cnt_d = wait_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            ir_q       <= '0;
            wait_cnt_q <= '0;
            branch_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q == FETCH && mem_ack)
                ir_q <= mem_rdata;
            if (state_q == EXECUTE && opcode == OP_BCC)
                branch_q <= br_cond;
            if (state_d == FAULT)
                fault_q <= 1'b1;
        end
    end

    // Every output collapses to zero while reset is held, independent of register contents.
    always_comb begin
        fetch       = 1'b0;
        execute     = 1'b0;
        memory      = 1'b0;
        ext_op      = 1'b0;
        reg_write   = 1'b0;
        dest        = '0;
        srcA        = '0;
        srcB        = '0;
        shift_op    = '0;
        opB_mux_sel = 1'b0;
        alu_func    = '0;
        cc_en       = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    fetch     = 1'b1;
                    mem_ren   = 1'b1;
                    dest      = '1;
                    srcA      = '1;
                    reg_write = mem_ack;
                end
                EXECUTE: begin
                    execute = 1'b1;
                    if (opcode == OP_BCC) begin
                        dest        = '1;
                        srcA        = '1;
                        alu_func    = OP_BCC;
                        ext_op      = 1'b1;
                        opB_mux_sel = 1'b1;
                        reg_write   = br_cond;
                    end else if (opcode == OP_LDST) begin
                        srcA        = REG_AW'(ir_q[7:5]);
                        alu_func    = OP_LDST;
                        opB_mux_sel = 1'b1;
                    end else begin
                        dest      = REG_AW'(ir_q[10:8]);
                        srcA      = REG_AW'(ir_q[7:5]);
                        alu_func  = opcode;
                        cc_en     = ir_q[11];
                        reg_write = 1'b1;
                        if (ir_q[12]) begin
                            opB_mux_sel = 1'b1;
                        end else begin
                            srcB     = REG_AW'(ir_q[4:2]);
                            shift_op = ir_q[1:0];
                        end
                    end
                end
                MEMORY: begin
                    memory = 1'b1;
                    if (ir_q[11]) begin
                        mem_wen = 1'b1;
                        srcA    = REG_AW'(ir_q[10:8]);
                    end else begin
                        mem_ren   = 1'b1;
                        dest      = REG_AW'(ir_q[10:8]);
                        reg_write = mem_ack;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ir           = rst_n ? ir_q : '0;
    assign branch_taken = rst_n & branch_q;
    assign fault        = rst_n & fault_q;

`ifdef STUMP_CTRL_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if ((state_q == EXECUTE && state_d == FETCH) || (state_q == MEMORY && mem_ack))
                retired_q <= retired_q + 32'd1;
            if (waiting && !mem_ack)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign retired      = rst_n ? retired_q : '0;
    assign stall_cycles = rst_n ? stall_q : '0;
`endif

endmodule

// File: tb/tb_stump_control_seq.sv
// Bench for stump_control_seq: directed scenarios with literal checks, then randomized traffic
// compared every cycle against a phase-level behavioural model.
module tb_stump_control_seq;

    localparam int TO = 4;
    localparam int PH_FETCH = 0, PH_EXEC = 1, PH_MEM = 2, PH_FAULT = 3;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [3:0]  cc;
    logic        fetch, execute, memory;
    logic [15:0] ir;
    logic        ext_op, reg_write;
    logic [2:0]  dest, srcA, srcB;
    logic [1:0]  shift_op;
    logic        opB_mux_sel;
    logic [2:0]  alu_func;
    logic        cc_en, mem_ren, mem_wen, branch_taken, fault;
`ifdef STUMP_CTRL_PERF_EN
    logic [31:0] retired, stall_cycles;
`endif

    stump_control_seq #(.DATA_W(16), .REG_AW(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .cc(cc),
        .fetch(fetch), .execute(execute), .memory(memory), .ir(ir),
        .ext_op(ext_op), .reg_write(reg_write), .dest(dest), .srcA(srcA), .srcB(srcB),
        .shift_op(shift_op), .opB_mux_sel(opB_mux_sel), .alu_func(alu_func), .cc_en(cc_en),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .branch_taken(branch_taken), .fault(fault)
`ifdef STUMP_CTRL_PERF_EN
        , .retired(retired), .stall_cycles(stall_cycles)
`endif
    );

    typedef struct packed {
        logic        fetch, execute, memory;
        logic [15:0] ir;
        logic        ext_op, reg_write;
        logic [2:0]  dest, srcA, srcB;
        logic [1:0]  shift_op;
        logic        opb;
        logic [2:0]  alu;
        logic        cc_en, ren, wen, bt, fault;
    } outs_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_printed = 0;

    // Behavioural model: phase, cycles spent waiting in the current phase, and architectural flags.
    int          m_phase = PH_FETCH;
    int          m_wait  = 0;
    logic [15:0] m_ir    = '0;
    logic        m_bt    = 1'b0;
    logic        m_fault = 1'b0;
    int unsigned m_retired = 0;
    int unsigned m_stall   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Odd codes test a base condition, the even code below it is its complement.
    function automatic logic cond_taken(input logic [3:0] code, input logic [3:0] f);
        logic n, z, v, c;
        logic [7:0] base;
        logic [2:0] k;
        {n, z, v, c} = f;
        base = {(v ^ n) | z, v ^ n, n, v, z, c, c | z, 1'b0};
        k = code[3:1];
        return code[0] ? base[k] : !base[k];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    initial begin
        outs_t e, a;
        logic [2:0] op;
        forever begin
            @(negedge clk);
            e = '0;
            op = m_ir[15:13];
            if (rst_n) begin
                e.ir = m_ir;
                e.bt = m_bt;
                e.fault = m_fault;
                if (m_phase == PH_FETCH) begin
                    e.fetch = 1; e.ren = 1; e.dest = 3'd7; e.srcA = 3'd7; e.reg_write = mem_ack;
                end else if (m_phase == PH_EXEC) begin
                    e.execute = 1;
                    e.alu = op;
                    if (op == 3'd7) begin
                        e.dest = 3'd7; e.srcA = 3'd7; e.ext_op = 1; e.opb = 1;
                        e.reg_write = cond_taken(m_ir[11:8], cc);
                    end else if (op == 3'd6) begin
                        e.srcA = m_ir[7:5]; e.opb = 1;
                    end else begin
                        e.dest = m_ir[10:8]; e.srcA = m_ir[7:5]; e.cc_en = m_ir[11]; e.reg_write = 1;
                        e.opb = m_ir[12];
                        e.srcB = m_ir[12] ? 3'd0 : m_ir[4:2];
                        e.shift_op = m_ir[12] ? 2'd0 : m_ir[1:0];
                    end
                end else if (m_phase == PH_MEM) begin
                    e.memory = 1;
                    if (m_ir[11]) begin
                        e.wen = 1; e.srcA = m_ir[10:8];
                    end else begin
                        e.ren = 1; e.dest = m_ir[10:8]; e.reg_write = mem_ack;
                    end
                end
            end
            a = {fetch, execute, memory, ir, ext_op, reg_write, dest, srcA, srcB, shift_op,
                 opB_mux_sel, alu_func, cc_en, mem_ren, mem_wen, branch_taken, fault};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                if (n_printed < 20) begin
                    n_printed++;
                    $display("FAIL cycle_outputs t=%0t phase=%0d: got %h expected %h", $time, m_phase, a, e);
                end
            end
`ifdef STUMP_CTRL_PERF_EN
            n_checks++;
            if (retired !== (rst_n ? m_retired : 0) || stall_cycles !== (rst_n ? m_stall : 0)) begin
                n_fail++;
                if (n_printed < 20) begin
                    n_printed++;
                    $display("FAIL perf_counters t=%0t: got %0d/%0d expected %0d/%0d", $time,
                             retired, stall_cycles, m_retired, m_stall);
                end
            end
`endif
            if (!rst_n) begin
                m_phase = PH_FETCH; m_wait = 0; m_ir = '0; m_bt = 0; m_fault = 0;
                m_retired = 0; m_stall = 0;
            end else if (m_phase == PH_FETCH || m_phase == PH_MEM) begin
                if (mem_ack) begin
                    if (m_phase == PH_FETCH) begin
                        m_ir = mem_rdata;
                        m_phase = PH_EXEC;
                    end else begin
                        m_retired++;
                        m_phase = PH_FETCH;
                    end
                    m_wait = 0;
                end else begin
                    m_stall++;
                    m_wait++;
                    if (m_wait >= TO) begin
                        m_phase = PH_FAULT;
                        m_fault = 1;
                    end
                end
            end else if (m_phase == PH_EXEC) begin
                if (op == 3'd7) m_bt = cond_taken(m_ir[11:8], cc);
                if (op == 3'd6) begin
                    m_phase = PH_MEM;
                end else begin
                    m_phase = PH_FETCH;
                    m_retired++;
                end
                m_wait = 0;
            end
        end
    end

    task automatic set_in(input logic ack, input logic [15:0] rd, input logic [3:0] c);
        mem_ack = ack; mem_rdata = rd; cc = c;
        #2;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 16'h0, 4'h0);
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
    endtask

    task automatic fetch_instr(input logic [15:0] instr, input int waits);
        for (int i = 0; i < waits; i++) begin
            set_in(0, 16'hFFFF, 4'h0);
            next_cyc();
        end
        set_in(1, instr, 4'h0);
        next_cyc();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0; cc = '0;
        @(posedge clk); #1;
        set_in(0, 16'h0, 4'h0);
        check("reset_fetch_forced_low", fetch, 0);
        check("reset_ren_forced_low", mem_ren, 0);
        next_cyc();
        rst_n = 1'b1;

        // ADD R1,R1,R0 with ack on the third fetch cycle
        set_in(0, 16'h0, 4'h0);
        check("t1_fetch_c1", fetch, 1);
        check("t1_regwrite_c1", reg_write, 0);
        check("t1_ir_reset", ir, 16'h0000);
        next_cyc();
        set_in(0, 16'h0, 4'h0);
        check("t1_fetch_c2", fetch, 1);
        check("t1_regwrite_c2", reg_write, 0);
        next_cyc();
        set_in(1, 16'h0123, 4'h0);
        check("t1_fetch_c3", fetch, 1);
        check("t1_regwrite_ack", reg_write, 1);
        next_cyc();
        set_in(0, 16'h0, 4'h0);
        check("t1_execute", execute, 1);
        check("t1_ir", ir, 16'h0123);
        check("t1_dest", dest, 1);
        check("t1_srcA", srcA, 1);
        check("t1_srcB", srcB, 0);
        check("t1_alu", alu_func, 0);
        next_cyc();

        // LD R6,[R7,#0] with ack on the third memory cycle
        fetch_instr(16'hC6E0, 0);
        set_in(0, 16'h0, 4'h0);
        check("t2_execute", execute, 1);
        check("t2_alu", alu_func, 3'b110);
        check("t2_opb", opB_mux_sel, 1);
        next_cyc();
        for (int i = 0; i < 3; i++) begin
            set_in(i == 2, 16'h0, 4'h0);
            check("t2_memory", memory, 1);
            check("t2_ren", mem_ren, 1);
            check("t2_regwrite", reg_write, (i == 2) ? 1 : 0);
            next_cyc();
        end
        set_in(0, 16'h0, 4'h0);
        check("t2_back_to_fetch", fetch, 1);

        // BCC cond 7 (Z): taken with Z set, not taken with flags clear
        fetch_instr(16'hE705, 0);
        set_in(0, 16'h0, 4'b0100);
        check("t3_taken_regwrite", reg_write, 1);
        check("t3_ext_op", ext_op, 1);
        next_cyc();
        set_in(0, 16'h0, 4'h0);
        check("t3_branch_taken", branch_taken, 1);
        next_cyc();
        fetch_instr(16'hE705, 0);
        set_in(0, 16'h0, 4'b0000);
        check("t3_not_taken_regwrite", reg_write, 0);
        next_cyc();
        set_in(0, 16'h0, 4'h0);
        check("t3_branch_not_taken", branch_taken, 0);

        // Timeout in FETCH: four empty wait cycles, then FAULT; late ack ignored
        for (int i = 0; i < TO; i++) begin
            set_in(0, 16'h0, 4'h0);
            check("t4_still_fetch", fetch, 1);
            next_cyc();
        end
        set_in(0, 16'h0, 4'h0);
        check("t4_fault", fault, 1);
        check("t4_fetch_off", fetch, 0);
        check("t4_ren_off", mem_ren, 0);
        next_cyc();
        set_in(1, 16'h0123, 4'h0);
        check("t4_late_ack_regwrite", reg_write, 0);
        next_cyc();
        set_in(0, 16'h0, 4'h0);
        check("t4_fault_held", fault, 1);
        check("t4_exec_off", execute, 0);
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        set_in(0, 16'h0, 4'h0);
        check("t4_post_reset_fetch", fetch, 1);
        check("t4_post_reset_fault", fault, 0);

        // Ack on exactly the TIMEOUT-th wait cycle, in FETCH and in MEMORY
        for (int i = 0; i < TO - 1; i++) begin set_in(0, 16'h0, 4'h0); next_cyc(); end
        set_in(1, 16'hC6E0, 4'h0);
        check("t5_fetch_edge_fault", fault, 0);
        next_cyc();
        set_in(0, 16'h0, 4'h0);
        check("t5_exec", execute, 1);
        next_cyc();
        for (int i = 0; i < TO - 1; i++) begin set_in(0, 16'h0, 4'h0); next_cyc(); end
        set_in(1, 16'h0, 4'h0);
        check("t5_mem_edge_regwrite", reg_write, 1);
        check("t5_mem_edge_dest", dest, 6);
        next_cyc();
        set_in(0, 16'h0, 4'h0);
        check("t5_mem_edge_fetch", fetch, 1);
        check("t5_mem_edge_fault", fault, 0);

`ifdef STUMP_CTRL_PERF_EN
        // Five instructions: stalls 1 (fetch) + 2 (store) + 2 (fetch) = 5
        do_reset();
        fetch_instr(16'h0123, 1);
        set_in(0, 16'h0, 4'h0); next_cyc();
        fetch_instr(16'hD9E0, 0);
        set_in(0, 16'h0, 4'h0); next_cyc();
        set_in(0, 16'h0, 4'h0); check("perf_store_wen", mem_wen, 1); next_cyc();
        set_in(0, 16'h0, 4'h0); next_cyc();
        set_in(1, 16'h0, 4'h0); next_cyc();
        fetch_instr(16'hE005, 2);
        set_in(0, 16'h0, 4'h0); next_cyc();
        fetch_instr(16'h0123, 0);
        set_in(0, 16'h0, 4'h0); next_cyc();
        fetch_instr(16'hC6E0, 0);
        set_in(0, 16'h0, 4'h0); next_cyc();
        set_in(1, 16'h0, 4'h0); next_cyc();
        set_in(0, 16'h0, 4'h0);
        check("perf_retired", retired, 5);
        check("perf_stall", stall_cycles, 5);
`endif

        // Randomized traffic; faults are cleared by occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n     = !((m_phase == PH_FAULT && $urandom_range(3) == 0) || $urandom_range(299) == 0);
            mem_ack   = ($urandom_range(9) < 6);
            mem_rdata = 16'($urandom);
            cc        = 4'($urandom);
            next_cyc();
        end
        rst_n = 1'b1;
        mem_ack = 1'b0;
        next_cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
